// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-port arbiter sharing one memory bus between an instruction-fetch
//   read port (if_*) and a load/store data port (d_*). Data normally wins a
//   simultaneous request; after MAX_WAIT consecutive losses fetch is forced
//   to win so it cannot starve. One transaction is outstanding at a time.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   if_req, if_addr             fetch read request and address
//   if_gnt, if_valid, if_rdata  fetch grant pulse, data-valid pulse, read data
//   d_req, d_we, d_addr,
//   d_wdata                     data request (d_we=1 store), address, store data
//   d_gnt, d_valid, d_rdata     data grant pulse, completion pulse, load data
//   mem_req, mem_we, mem_addr,
//   mem_wdata                   shared memory request bus
//   mem_ready, mem_rdata        memory completion handshake and read data
//   busy                        1 whenever a transaction is in flight
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int REG_BITS = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [REG_BITS-1:0] if_addr,
    output logic                if_gnt,
    output logic                if_valid,
    output logic [REG_BITS-1:0] if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [REG_BITS-1:0] d_addr,
    input  logic [REG_BITS-1:0] d_wdata,
    output logic                d_gnt,
    output logic                d_valid,
    output logic [REG_BITS-1:0] d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [REG_BITS-1:0] mem_addr,
    output logic [REG_BITS-1:0] mem_wdata,
    input  logic                mem_ready,
    input  logic [REG_BITS-1:0] mem_rdata,
    output logic                busy
);

    localparam int              CW      = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_wait_cnt;
    logic                  r_if_gnt;
    logic                  r_d_gnt;
    logic                  r_if_valid;
    logic                  r_d_valid;
    logic [REG_BITS-1:0]   r_if_rdata;
    logic [REG_BITS-1:0]   r_d_rdata;
    logic                  r_mem_we;
    logic [REG_BITS-1:0]   r_mem_addr;
    logic [REG_BITS-1:0]   r_mem_wdata;

    logic                  w_starve;
    logic                  w_grant_if;
    logic                  w_grant_d;
    logic                  w_done_if;
    logic                  w_done_d;

    assign w_starve = (r_wait_cnt >= MAX_CNT);

    // Next-state logic; data has priority unless fetch has starved.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (d_req && !w_starve)
                    w_next = BUSY_D;
                else if (if_req)
                    w_next = BUSY_IF;
            end
            BUSY_IF: if (mem_ready) w_next = IDLE;
            BUSY_D:  if (mem_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_grant_if = (r_state == IDLE) && (w_next == BUSY_IF);
    assign w_grant_d  = (r_state == IDLE) && (w_next == BUSY_D);
    assign w_done_if  = (r_state == BUSY_IF) && mem_ready;
    assign w_done_d   = (r_state == BUSY_D) && mem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_if_gnt    <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state    <= w_next;
            r_if_gnt   <= w_grant_if;
            r_d_gnt    <= w_grant_d;
            r_if_valid <= w_done_if;
            r_d_valid  <= w_done_d;

            // Count consecutive losses of a waiting fetch; any other IDLE
            // outcome (fetch wins, or fetch not requesting) clears it.
            if (r_state == IDLE) begin
                if (w_grant_d && if_req) begin
                    if (r_wait_cnt != MAX_CNT)
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                end else begin
                    r_wait_cnt <= '0;
                end
            end

            // Capture the winner's request; held for the whole transaction.
            // mem_wdata is left alone on a fetch since nothing is written.
            if (w_grant_d) begin
                r_mem_addr  <= d_addr;
                r_mem_we    <= d_we;
                r_mem_wdata <= d_wdata;
            end else if (w_grant_if) begin
                r_mem_addr  <= if_addr;
                r_mem_we    <= 1'b0;
            end

            if (w_done_if)
                r_if_rdata <= mem_rdata;
            // Stores keep the last load value visible on d_rdata.
            if (w_done_d && !r_mem_we)
                r_d_rdata <= mem_rdata;
        end
    end

    assign busy      = (r_state != IDLE);
    assign mem_req   = busy;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_gnt    = r_if_gnt;
    assign d_gnt     = r_d_gnt;
    assign if_valid  = r_if_valid;
    assign d_valid   = r_d_valid;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed stimulus with a scoreboard: expected grants and responses are
//   queued by the stimulus process, and a monitor pops/compares them whenever
//   the arbiter raises a gnt or valid. Cycle-exact checks are made inline.
//   Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int RB = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [RB-1:0] if_addr;
    logic          if_gnt, if_valid;
    logic [RB-1:0] if_rdata;
    logic          d_req, d_we;
    logic [RB-1:0] d_addr, d_wdata;
    logic          d_gnt, d_valid;
    logic [RB-1:0] d_rdata;
    logic          mem_req, mem_we;
    logic [RB-1:0] mem_addr, mem_wdata;
    logic          mem_ready;
    logic [RB-1:0] mem_rdata;
    logic          busy;

    always #5 clk = ~clk;

    mem_arbiter #(.REG_BITS(RB), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr),
        .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Memory contents: one fixed word at 0x10, otherwise address ^ 0xCAFE0000.
    always_comb mem_rdata = (mem_addr == 32'h10) ? 32'hDEADBEEF
                                                 : (mem_addr ^ 32'hCAFE0000);

    typedef struct packed {
        logic          is_d;
        logic          we;
        logic [RB-1:0] addr;
        logic [RB-1:0] wdata;
    } gnt_t;

    typedef struct packed {
        logic          is_d;
        logic [RB-1:0] rdata;
    } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];
    gnt_t ge;
    rsp_t re;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic all_out_zero();
        return ~|{if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
                  mem_req, mem_we, mem_addr, mem_wdata, busy};
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if_gnt || d_gnt) begin
                chk("gnt_exclusive", {63'd0, if_gnt && d_gnt}, 64'd0);
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", 64'd1, 64'd0);
                end else begin
                    ge = gq.pop_front();
                    chk("gnt_port", {63'd0, d_gnt}, {63'd0, ge.is_d});
                    chk("gnt_addr", {32'd0, mem_addr}, {32'd0, ge.addr});
                    chk("gnt_we", {63'd0, mem_we}, {63'd0, ge.we});
                    if (ge.we)
                        chk("gnt_wdata", {32'd0, mem_wdata}, {32'd0, ge.wdata});
                end
            end
            if (if_valid || d_valid) begin
                chk("valid_exclusive", {63'd0, if_valid && d_valid}, 64'd0);
                if (rq.size() == 0) begin
                    chk("valid_unexpected", 64'd1, 64'd0);
                end else begin
                    re = rq.pop_front();
                    chk("valid_port", {63'd0, d_valid}, {63'd0, re.is_d});
                    chk("valid_rdata", {32'd0, d_valid ? d_rdata : if_rdata},
                        {32'd0, re.rdata});
                end
            end
        end
    end

    initial begin
        int ndg;
        logic got;

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs_zero", {63'd0, all_out_zero()}, 64'd1);
        chk("reset_wait_cnt", 64'(dut.r_wait_cnt), 64'd0);
        rst_n = 1'b1;

        // Single fetch, memory ready at once.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10; mem_ready = 1'b1;
        gq.push_back('{1'b0, 1'b0, 32'h10, 32'h0});
        rq.push_back('{1'b0, 32'hDEADBEEF});
        @(negedge clk);                                  // cycle 1
        chk("t1_if_gnt", {63'd0, if_gnt}, 64'd1);
        chk("t1_mem_req", {63'd0, mem_req}, 64'd1);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        if_req = 1'b0;
        @(negedge clk);                                  // cycle 2
        chk("t1_if_valid", {63'd0, if_valid}, 64'd1);
        chk("t1_if_rdata", {32'd0, if_rdata}, 64'hDEADBEEF);
        chk("t1_busy_c2", {63'd0, busy}, 64'd0);

        // Simultaneous fetch and load: data first, then fetch.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        gq.push_back('{1'b1, 1'b0, 32'h20, 32'h0});
        gq.push_back('{1'b0, 1'b0, 32'h40, 32'h0});
        rq.push_back('{1'b1, 32'hCAFE0020});
        rq.push_back('{1'b0, 32'hCAFE0040});
        @(negedge clk);                                  // cycle 1
        chk("t2_d_gnt", {63'd0, d_gnt}, 64'd1);
        chk("t2_mem_addr", {32'd0, mem_addr}, 64'h20);
        chk("t2_mem_we", {63'd0, mem_we}, 64'd0);
        chk("t2_wait_cnt_1", 64'(dut.r_wait_cnt), 64'd1);
        d_req = 1'b0;
        @(negedge clk);                                  // cycle 2
        chk("t2_d_valid", {63'd0, d_valid}, 64'd1);
        @(negedge clk);                                  // cycle 3
        chk("t2_if_gnt", {63'd0, if_gnt}, 64'd1);
        chk("t2_wait_cnt_clr", 64'(dut.r_wait_cnt), 64'd0);
        if_req = 1'b0;
        @(negedge clk);                                  // cycle 4
        chk("t2_if_valid", {63'd0, if_valid}, 64'd1);

        // Continuous stores against continuous fetch: starvation guard.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h1000;
        for (int i = 0; i < MW; i++) begin
            gq.push_back('{1'b1, 1'b1, 32'h100, 32'h1000 + 32'(i)});
            rq.push_back('{1'b1, 32'hCAFE0020});
        end
        gq.push_back('{1'b0, 1'b0, 32'h80, 32'h0});
        rq.push_back('{1'b0, 32'hCAFE0080});
        ndg = 0; got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (d_gnt) begin
                ndg++;
                d_wdata = d_wdata + 32'd1;
            end
            if (if_gnt) begin
                got = 1'b1;
                if_req = 1'b0;
                d_req = 1'b0;
            end
        end
        chk("t3_fetch_granted", {63'd0, got}, 64'd1);
        chk("t3_data_wins", 64'(ndg), 64'(MW));
        repeat (2) @(negedge clk);

        // Store with mem_ready held low for three cycles.
        mem_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234;
        gq.push_back('{1'b1, 1'b1, 32'h200, 32'h1234});
        rq.push_back('{1'b1, 32'hCAFE0020});
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("t4_mem_req", {63'd0, mem_req}, 64'd1);
            chk("t4_mem_we", {63'd0, mem_we}, 64'd1);
            chk("t4_mem_wdata", {32'd0, mem_wdata}, 64'h1234);
            chk("t4_no_valid", {63'd0, d_valid}, 64'd0);
            if (c == 1) d_req = 1'b0;
            if (c == 4) mem_ready = 1'b1;
        end
        @(negedge clk);                                  // cycle 5
        chk("t4_d_valid", {63'd0, d_valid}, 64'd1);
        chk("t4_d_rdata_held", {32'd0, d_rdata}, 64'hCAFE0020);
        chk("t4_idle", {63'd0, busy}, 64'd0);

        // Reset in the middle of a stalled load.
        @(negedge clk);
        mem_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        gq.push_back('{1'b1, 1'b0, 32'h300, 32'h0});
        @(negedge clk);                                  // cycle 1
        chk("t5_d_gnt", {63'd0, d_gnt}, 64'd1);
        d_req = 1'b0;
        @(negedge clk);                                  // cycle 2
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_mem_req_dropped", {63'd0, mem_req}, 64'd0);
        chk("t5_busy_dropped", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        got = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (d_valid) got = 1'b1;
        end
        chk("t5_no_d_valid", {63'd0, got}, 64'd0);

        // Idle with no requests: everything stays zero.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t6_idle_outputs", {63'd0, all_out_zero()}, 64'd1);
            chk("t6_idle_wait_cnt", 64'(dut.r_wait_cnt), 64'd0);
        end

        chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
        chk("rsp_queue_drained", 64'(rq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
